// File: rtl/instruction_queue_pkg.sv
// Shared CPU definitions for the fetch/decode path: default word and field widths,
// opcode encoding and instruction field slice positions. Also used by the decoder.
package instruction_queue_pkg;

    localparam int IQ_DATA_W = 8;
    localparam int IQ_OPC_W  = 4;
    localparam int IQ_DEPTH  = 4;

    // Field slice positions within an instruction word
    localparam int OPC_MSB  = IQ_DATA_W - 1;
    localparam int OPC_LSB  = IQ_DATA_W - IQ_OPC_W;
    localparam int OPND_MSB = IQ_DATA_W - IQ_OPC_W - 1;
    localparam int OPND_LSB = 0;

    typedef enum logic [IQ_OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_JMP   = 4'h7,
        OP_BRZ   = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

    // Pointer width for a queue of the given depth
    function automatic int unsigned iqPtrWidth(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// master = fetch/decode environment, slave = the queue itself.
interface instruction_queue_if
    import instruction_queue_pkg::*;
#(
    parameter int DATA_W = IQ_DATA_W,
    parameter int OPC_W  = IQ_OPC_W,
    parameter int DEPTH  = IQ_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OPC_W-1:0]        opcode;
    logic [DATA_W-OPC_W-1:0] operand;
    logic [AW:0]             count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, opcode, operand, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, opcode, operand, count
    );

endinterface

// File: rtl/instruction_queue_iq_ptr_ctrl.sv
// Pointer and occupancy control for the instruction queue: write/read pointers
// wrapping modulo DEPTH, occupancy count, full/empty flags and flush handling.
module iq_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    output logic [AW-1:0] o_wrPtr,
    output logic [AW-1:0] o_rdPtr,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    // Advance pointers and track occupancy; flush wipes the queue and beats any push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wrPtr = r_wrPtr;
    assign o_rdPtr = r_rdPtr;
    assign o_count = r_count;

endmodule

// File: rtl/instruction_queue.sv
// DEPTH-entry instruction prefetch queue between fetch and decode. Holds the
// storage array, splits the head word into opcode/operand and, when the macro
// IQ_BYPASS_EN is defined, forwards a fetched word straight to decode while empty.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DATA_W = IQ_DATA_W,
    parameter int OPC_W  = IQ_OPC_W,
    parameter int DEPTH  = IQ_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    instruction_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_wrPtr;
    logic [AW-1:0]     w_rdPtr;
    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_outValid;
    logic [DATA_W-1:0] w_head;

`ifdef IQ_BYPASS_EN
    // An empty queue shows the incoming word to decode in the same cycle
    assign w_bypass = w_empty & bus.in_valid & ~bus.flush & rst_n;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word taken by decode this cycle never needs storing
    assign w_push     = bus.in_valid & ~w_full & ~(w_bypass & bus.out_ready);
    assign w_pop      = ~w_empty & bus.out_ready;
    assign w_outValid = ~w_empty | w_bypass;
    assign w_head     = w_bypass ? bus.in_data : r_mem[w_rdPtr];

    iq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptrCtrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_wrPtr (w_wrPtr),
        .o_rdPtr (w_rdPtr),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Store accepted fetch words; storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push & ~bus.flush) begin
            r_mem[w_wrPtr] <= bus.in_data;
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = w_outValid;
    assign bus.count     = w_count;
    assign bus.opcode    = w_outValid ? w_head[DATA_W-1 -: OPC_W] : '0;
    assign bus.operand   = w_outValid ? w_head[DATA_W-OPC_W-1:0] : '0;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus random traffic,
// checked by a negedge monitor against a queue-based reference of the expected words.
// Define IQ_BYPASS_EN to exercise the zero-latency bypass build.
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;
    localparam int DEPTH  = 4;
`ifdef IQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   monEn    = 1'b0;
    logic [DATA_W-1:0] expQ [$];

    instruction_queue_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH)) bus ();

    instruction_queue #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and record in the
    // reference which word, if any, the queue must store at the coming edge
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
        bit store;
        int sz;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        sz    = expQ.size();
        store = v && !f && (sz < DEPTH) && !(BYPASS && sz == 0 && r);
        @(posedge clk);
        if (f) expQ.delete();
        else if (store) expQ.push_back(d);
        #1;
    endtask

    // Monitor: compare the presented head and status with the reference, retire consumed words
    always @(negedge clk) begin
        bit          expValid;
        logic [7:0]  expHead;
        int          sz;
        if (monEn && rst_n) begin
            sz       = expQ.size();
            expValid = 1'b0;
            expHead  = '0;
            if (sz > 0) begin
                expValid = 1'b1;
                expHead  = expQ[0];
            end else if (BYPASS && bus.in_valid && !bus.flush) begin
                expValid = 1'b1;
                expHead  = bus.in_data;
            end
            checkOutput("count", int'(bus.count), sz);
            checkOutput("in_ready", int'(bus.in_ready), int'(sz != DEPTH));
            checkOutput("out_valid", int'(bus.out_valid), int'(expValid));
            checkOutput("opcode", int'(bus.opcode), int'(expHead[7:4]));
            checkOutput("operand", int'(bus.operand), int'(expHead[3:0]));
            if (expValid && bus.out_ready && sz > 0) void'(expQ.pop_front());
        end
    end

    initial begin
        logic [7:0] fillWords [4];
        fillWords = '{8'hAF, 8'h3C, 8'h05, 8'h71};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_count", int'(bus.count), 0);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        monEn = 1'b1;

        // Asynchronous reset with three words queued
        applyStimulus(1, 8'h11, 0, 0);
        applyStimulus(1, 8'h22, 0, 0);
        applyStimulus(1, 8'h33, 0, 0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        monEn = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("async_rst_count", int'(bus.count), 0);
        checkOutput("async_rst_opcode", int'(bus.opcode), 0);
        checkOutput("async_rst_operand", int'(bus.operand), 0);
        checkOutput("async_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        monEn = 1'b1;

        // Fill to DEPTH, reject a fifth word, then drain in order
        foreach (fillWords[i]) applyStimulus(1, fillWords[i], 0, 0);
        applyStimulus(1, 8'hE2, 0, 0);
        repeat (5) applyStimulus(0, 8'h00, 1, 0);

        // Push/pop pairs across pointer wrap with one word resident
        applyStimulus(1, 8'h5A, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h60 + i), 1, 0);
        applyStimulus(0, 8'h00, 1, 0);

        // Simultaneous push and pop at count 2
        applyStimulus(1, 8'h12, 0, 0);
        applyStimulus(1, 8'h34, 0, 0);
        applyStimulus(1, 8'h9B, 1, 0);
        repeat (3) applyStimulus(0, 8'h00, 1, 0);

        // Flush with a concurrent push that must be discarded
        applyStimulus(1, 8'hA1, 0, 0);
        applyStimulus(1, 8'hB2, 0, 0);
        applyStimulus(1, 8'hC3, 0, 0);
        applyStimulus(1, 8'h44, 0, 1);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("post_flush_count", int'(bus.count), 0);
        checkOutput("post_flush_out_valid", int'(bus.out_valid), 0);

        // Empty queue offered a word while decode is ready
        applyStimulus(1, 8'hC7, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 19) == 0);
        end
        repeat (DEPTH + 1) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("final_count", int'(bus.count), 0);

        monEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
